// File: rtl/sseg_pkg.sv
// Shared segment definitions for the seven-segment scan multiplexer.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package sseg_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    // Bit order of a segment vector, MSB first
    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_t;

    localparam seg_t SEG_0    = 7'b1000000;
    localparam seg_t SEG_1    = 7'b1111001;
    localparam seg_t SEG_2    = 7'b0100100;
    localparam seg_t SEG_3    = 7'b0110000;
    localparam seg_t SEG_4    = 7'b0011001;
    localparam seg_t SEG_5    = 7'b0010010;
    localparam seg_t SEG_6    = 7'b0000010;
    localparam seg_t SEG_7    = 7'b1111000;
    localparam seg_t SEG_8    = 7'b0000000;
    localparam seg_t SEG_9    = 7'b0010000;
    localparam seg_t SEG_DASH = 7'b0111111;
    localparam seg_t SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes A-F are shown as a dash so a corrupted counter is visible.
module bcd_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    seg_t pattern;

    always_comb begin
        pattern = SEG_DASH;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

    assign seg_c = pattern;

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed seven-segment driver with tear-free frame capture.
// Optional leading-zero blanking is enabled with `define LEADING_ZERO_BLANK_EN.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]       dp_mask,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [SEG_W-1:0]            sseg,
    output logic                        dp,
    output logic                        frame_tick
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]                  cnt_q,  cnt_d;
    logic [IDX_W-1:0]                  idx_q,  idx_d;
    logic [NUM_DIGITS-1:0][BCD_W-1:0]  shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]             shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]             an_q,   an_d;
    logic [SEG_W-1:0]                  sseg_q, sseg_d;
    logic                              dp_q,   dp_d;
    logic                              frame_tick_q, frame_tick_d;

    logic                              tc_c;
    logic                              wrap_c;
    logic [BCD_W-1:0]                  cur_bcd_c;
    logic [SEG_W-1:0]                  cur_seg_c;
    logic [NUM_DIGITS-1:0]             blank_c;

    assign tc_c      = (cnt_q == CNT_LAST);
    assign wrap_c    = tc_c && (idx_q == IDX_LAST);
    assign cur_bcd_c = shadow_q[idx_q];

    bcd_to_sseg u_bcd_to_sseg (
        .bcd   (cur_bcd_c),
        .seg_c (cur_seg_c)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run_c;

    // Walk down from the top digit; blanking stops at the first nonzero or dp digit
    always_comb begin
        blank_c    = '0;
        zero_run_c = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run_c = zero_run_c && (shadow_q[i] == 4'd0) && !shadow_dp_q[i];
            blank_c[i] = zero_run_c;
        end
    end
`else
    assign blank_c = '0;
`endif

    // Next-state and registered-output computation
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        an_d         = '1;
        sseg_d       = SEG_OFF;
        dp_d         = 1'b1;
        frame_tick_d = 1'b0;

        if (enable) begin
            an_d   = blank_c[idx_q] ? '1 : ~(NUM_DIGITS'(1) << idx_q);
            sseg_d = cur_seg_c;
            dp_d   = ~shadow_dp_q[idx_q];

            cnt_d = tc_c ? '0 : cnt_q + 1'b1;
            if (tc_c) begin
                idx_d = wrap_c ? '0 : idx_q + 1'b1;
            end

            // Capture only at the frame boundary so a frame never tears
            if (wrap_c) begin
                shadow_d     = digits;
                shadow_dp_d  = dp_mask;
                frame_tick_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            an_q         <= '1;
            sseg_q       <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule
